// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-side bus bundle: ROM request/response plus the {pc, instr} handshake toward decode.
interface instr_fetch_ctrl_if #(
  parameter int A_WIDTH = 20
) ();
  logic               mem_req;
  logic [A_WIDTH-1:0] mem_addr;
  logic [31:0]        mem_rdata;
  logic               if_valid;
  logic [31:0]        if_instr;
  logic [A_WIDTH-1:0] if_pc;
  logic               if_ready;

  modport master (
    output mem_req, mem_addr, if_valid, if_instr, if_pc,
    input  mem_rdata, if_ready
  );

  modport slave (
    input  mem_req, mem_addr, if_valid, if_instr, if_pc,
    output mem_rdata, if_ready
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch sequencer: issues word fetches to the ROM, registers the returned
// word for one cycle, and queues {pc, instr} pairs in a small FIFO for decode.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// RUN    | issuing fetches whenever FIFO credit allows
// HALT   | fetch stopped by halt; FIFO keeps draining, waits for start
module instr_fetch_ctrl #(
  parameter int                 A_WIDTH  = 20,
  parameter int                 DEPTH    = 4,
  parameter logic [A_WIDTH-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               halt,
  input  logic               redirect,
  input  logic [A_WIDTH-1:0] redirect_pc,
  output logic               busy,
  instr_fetch_ctrl_if.master bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

  state_t             state, state_nxt;
  logic [A_WIDTH-1:0] fetch_pc;
  logic [CW-1:0]      count;
  logic               inflight;
  logic [31:0]        resp_word;
  logic [A_WIDTH-1:0] resp_pc;
  logic [PW-1:0]      wr_ptr, rd_ptr;
  logic [31:0]        fifo_instr [DEPTH];
  logic [A_WIDTH-1:0] fifo_pc    [DEPTH];

  logic req, valid, push, pop, credit_ok;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    // Credit uses the pre-pop count, so the FIFO can never be overrun by in-flight data.
    credit_ok = ({1'b0, count} + {{CW{1'b0}}, inflight}) < (CW + 1)'(DEPTH);
    req       = 1'b0;
    case (state)
      S_IDLE: if (start && !halt) state_nxt = S_RUN;
      S_RUN: begin
        if (halt) state_nxt = S_HALT;
        req = !halt && !redirect && credit_ok;
      end
      S_HALT: if (start && !halt) state_nxt = S_RUN;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign valid = (count != '0) && !redirect;
  assign push  = inflight && !redirect;
  assign pop   = valid && bus.if_ready;

  assign bus.mem_req  = req;
  assign bus.mem_addr = fetch_pc;
  assign bus.if_valid = valid;
  assign bus.if_instr = valid ? fifo_instr[rd_ptr] : '0;
  assign bus.if_pc    = valid ? fifo_pc[rd_ptr]    : '0;
  assign busy         = (state == S_RUN) || inflight;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_pc  <= RESET_PC;
      count     <= '0;
      inflight  <= 1'b0;
      resp_word <= '0;
      resp_pc   <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
    end else if (redirect) begin
      fetch_pc <= {redirect_pc[A_WIDTH-1:2], 2'b00};
      count    <= '0;
      inflight <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
    end else begin
      inflight <= req;
      if (req) begin
        fetch_pc  <= fetch_pc + A_WIDTH'(4);
        resp_word <= bus.mem_rdata;
        resp_pc   <= fetch_pc;
      end
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: head outputs are gated by valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_instr[wr_ptr] <= resp_word;
      fifo_pc[wr_ptr]    <= resp_pc;
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: per-cycle vector table, hand sequences for redirect/halt/reset,
// and a scoreboard that checks every decode handshake against the expected pc stream.
module tb_instr_fetch_ctrl;
  localparam int AW = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          start, halt, redirect, busy;
  logic [AW-1:0] redirect_pc;
  logic          start2, halt2, redirect2, busy2;
  logic [AW-1:0] redirect_pc2;

  instr_fetch_ctrl_if #(.A_WIDTH(AW)) bus1 ();
  instr_fetch_ctrl_if #(.A_WIDTH(AW)) bus2 ();

  function automatic logic [31:0] rom(input logic [AW-1:0] a);
    return 32'h0000_0013 + 32'(a >> 2) * 32'h0010_0080;
  endfunction

  assign bus1.mem_rdata = rom(bus1.mem_addr);
  assign bus2.mem_rdata = rom(bus2.mem_addr);

  instr_fetch_ctrl #(.A_WIDTH(AW), .DEPTH(4), .RESET_PC(20'h00000)) dut (
    .clk(clk), .rst(rst), .start(start), .halt(halt), .redirect(redirect),
    .redirect_pc(redirect_pc), .busy(busy), .bus(bus1)
  );

  instr_fetch_ctrl #(.A_WIDTH(AW), .DEPTH(4), .RESET_PC(20'hFFFFC)) dut_wrap (
    .clk(clk), .rst(rst), .start(start2), .halt(halt2), .redirect(redirect2),
    .redirect_pc(redirect_pc2), .busy(busy2), .bus(bus2)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic [AW-1:0] pc;
    logic [31:0]   instr;
  } pair_t;
  pair_t sb_q[$];

  task automatic sb_load(input logic [AW-1:0] pc0, input int n);
    pair_t p;
    logic [AW-1:0] pc;
    pc = pc0;
    for (int i = 0; i < n; i++) begin
      p.pc    = pc;
      p.instr = rom(pc);
      sb_q.push_back(p);
      pc = pc + AW'(4);
    end
  endtask

  always @(negedge clk) begin
    pair_t e;
    if (!rst && bus1.if_valid && bus1.if_ready) begin
      if (sb_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL sb_unexpected: got pc %h expected no handshake", bus1.if_pc);
      end else begin
        e = sb_q.pop_front();
        chk("sb_pc", 32'(bus1.if_pc), 32'(e.pc));
        chk("sb_instr", bus1.if_instr, e.instr);
      end
    end
  end

  typedef struct {
    bit            rst_first;
    bit            st, rdy;
    bit            e_req;
    logic [AW-1:0] e_addr;
    bit            e_valid;
    logic [AW-1:0] e_pc;
    bit            e_busy;
  } vec_t;
  vec_t tbl[$];

  task automatic row(input bit rf, input bit st, input bit rdy, input bit er,
                     input logic [AW-1:0] ea, input bit ev, input logic [AW-1:0] ep,
                     input bit eb);
    vec_t v;
    v.rst_first = rf; v.st = st; v.rdy = rdy; v.e_req = er; v.e_addr = ea;
    v.e_valid = ev; v.e_pc = ep; v.e_busy = eb;
    tbl.push_back(v);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 0; halt = 0; redirect = 0; redirect_pc = '0;
    start2 = 0; halt2 = 0; redirect2 = 0; redirect_pc2 = '0;
    bus1.if_ready = 0; bus2.if_ready = 0;
    sb_q.delete();
    @(negedge clk);
    chk("rst_req", bus1.mem_req, 0);
    chk("rst_addr", 32'(bus1.mem_addr), 0);
    chk("rst_valid", bus1.if_valid, 0);
    chk("rst_pc", 32'(bus1.if_pc), 0);
    chk("rst_instr", bus1.if_instr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_wrap_addr", 32'(bus2.mem_addr), 32'h000FFFFC);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Startup with decode always ready.
    row(1, 1, 1, 0, 20'h00, 0, 20'h0, 0);
    row(0, 0, 1, 1, 20'h00, 0, 20'h0, 1);
    row(0, 0, 1, 1, 20'h04, 0, 20'h0, 1);
    row(0, 0, 1, 1, 20'h08, 1, 20'h0, 1);
    row(0, 0, 1, 1, 20'h0C, 1, 20'h4, 1);
    row(0, 0, 1, 1, 20'h10, 1, 20'h8, 1);
    row(0, 0, 1, 1, 20'h14, 1, 20'hC, 1);
    // Backpressure: exactly four requests, then resume at 0x10.
    row(1, 1, 0, 0, 20'h00, 0, 20'h0, 0);
    row(0, 0, 0, 1, 20'h00, 0, 20'h0, 1);
    row(0, 0, 0, 1, 20'h04, 0, 20'h0, 1);
    row(0, 0, 0, 1, 20'h08, 1, 20'h0, 1);
    row(0, 0, 0, 1, 20'h0C, 1, 20'h0, 1);
    row(0, 0, 0, 0, 20'h10, 1, 20'h0, 1);
    row(0, 0, 0, 0, 20'h10, 1, 20'h0, 1);
    row(0, 0, 0, 0, 20'h10, 1, 20'h0, 1);
    row(0, 0, 1, 0, 20'h10, 1, 20'h0, 1);
    row(0, 0, 1, 1, 20'h10, 1, 20'h4, 1);
    row(0, 0, 1, 1, 20'h14, 1, 20'h8, 1);
    row(0, 0, 1, 1, 20'h18, 1, 20'hC, 1);
    row(0, 0, 1, 1, 20'h1C, 1, 20'h10, 1);

    start = 0; halt = 0; redirect = 0; redirect_pc = '0;
    start2 = 0; halt2 = 0; redirect2 = 0; redirect_pc2 = '0;
    bus1.if_ready = 0; bus2.if_ready = 0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].rst_first) begin
        do_reset();
        sb_load(20'h0, 40);
      end
      start = tbl[i].st;
      bus1.if_ready = tbl[i].rdy;
      @(negedge clk);
      chk($sformatf("v%0d_req", i), bus1.mem_req, tbl[i].e_req);
      chk($sformatf("v%0d_addr", i), 32'(bus1.mem_addr), 32'(tbl[i].e_addr));
      chk($sformatf("v%0d_valid", i), bus1.if_valid, tbl[i].e_valid);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      if (tbl[i].e_valid) begin
        chk($sformatf("v%0d_pc", i), 32'(bus1.if_pc), 32'(tbl[i].e_pc));
        chk($sformatf("v%0d_instr", i), bus1.if_instr, rom(tbl[i].e_pc));
      end
      tick();
    end

    // Redirect with 3 queued + 1 in flight, decode ready in the redirect cycle.
    do_reset();
    sb_load(20'h0, 40);
    start = 1; bus1.if_ready = 0;
    tick();
    start = 0;
    repeat (4) tick();
    redirect = 1; redirect_pc = 20'h00103; bus1.if_ready = 1;
    sb_q.delete();
    sb_load(20'h00100, 40);
    @(negedge clk);
    chk("redir_valid", bus1.if_valid, 0);
    chk("redir_req", bus1.mem_req, 0);
    tick();
    redirect = 0;
    @(negedge clk);
    chk("redir_req_t1", bus1.mem_req, 1);
    chk("redir_addr_t1", 32'(bus1.mem_addr), 32'h100);
    tick();
    @(negedge clk);
    chk("redir_addr_t2", 32'(bus1.mem_addr), 32'h104);
    chk("redir_valid_t2", bus1.if_valid, 0);
    tick();
    @(negedge clk);
    chk("redir_valid_t3", bus1.if_valid, 1);
    chk("redir_pc_t3", 32'(bus1.if_pc), 32'h100);
    tick();
    tick();
    // Redirect coinciding with a live handshake.
    chk("pre_redir2_valid", bus1.if_valid, 1);
    redirect = 1; redirect_pc = 20'h00040;
    sb_q.delete();
    sb_load(20'h00040, 40);
    @(negedge clk);
    chk("redir2_valid", bus1.if_valid, 0);
    chk("redir2_req", bus1.mem_req, 0);
    tick();
    redirect = 0;
    @(negedge clk);
    chk("redir2_addr", 32'(bus1.mem_addr), 32'h40);
    tick();
    tick();
    @(negedge clk);
    chk("redir2_head", 32'(bus1.if_pc), 32'h40);
    chk("redir2_head_valid", bus1.if_valid, 1);
    tick();

    // Halt: in-flight word delivered, busy drops, resume at next pc.
    do_reset();
    sb_load(20'h0, 40);
    start = 1; bus1.if_ready = 1;
    tick();
    start = 0;
    repeat (4) tick();
    halt = 1;
    @(negedge clk);
    chk("halt_req", bus1.mem_req, 0);
    chk("halt_busy", busy, 1);
    tick();
    @(negedge clk);
    chk("halt_busy_drop", busy, 0);
    chk("halt_valid", bus1.if_valid, 1);
    chk("halt_pc", 32'(bus1.if_pc), 32'hC);
    tick();
    halt = 0; start = 1;
    @(negedge clk);
    chk("halt_drained", bus1.if_valid, 0);
    chk("halt_req_off", bus1.mem_req, 0);
    tick();
    start = 0;
    @(negedge clk);
    chk("resume_req", bus1.mem_req, 1);
    chk("resume_addr", 32'(bus1.mem_addr), 32'h10);
    tick();
    tick();
    @(negedge clk);
    chk("resume_pc", 32'(bus1.if_pc), 32'h10);
    tick();

    // Asynchronous reset between edges.
    #2;
    rst = 1'b1;
    #1;
    chk("arst_req", bus1.mem_req, 0);
    chk("arst_valid", bus1.if_valid, 0);
    chk("arst_pc", 32'(bus1.if_pc), 0);
    chk("arst_instr", bus1.if_instr, 0);
    chk("arst_busy", busy, 0);
    chk("arst_addr", 32'(bus1.mem_addr), 0);
    sb_q.delete();
    tick();

    // pc wrap at the top of the address space.
    do_reset();
    start2 = 1; bus2.if_ready = 1;
    tick();
    start2 = 0;
    @(negedge clk);
    chk("wrap_req0", bus2.mem_req, 1);
    chk("wrap_addr0", 32'(bus2.mem_addr), 32'h000FFFFC);
    tick();
    @(negedge clk);
    chk("wrap_addr1", 32'(bus2.mem_addr), 32'h0);
    tick();
    @(negedge clk);
    chk("wrap_pc0", 32'(bus2.if_pc), 32'h000FFFFC);
    chk("wrap_instr0", bus2.if_instr, rom(20'hFFFFC));
    tick();
    @(negedge clk);
    chk("wrap_pc1", 32'(bus2.if_pc), 32'h0);
    chk("wrap_instr1", bus2.if_instr, rom(20'h0));
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
